program_loader: RTL and testbench
=================================

# program_loader

Serial boot loader for the single-cycle MIPS test top. It receives a program image over the board UART (`UART_RXD`) and writes it word by word into the instruction memory; the CPU datapath only ever reads that memory. While a load is in progress it holds the program counter and register file in reset through `busy`, then releases the CPU with PC at word 0.

## Interface
Parameters:
- `CLKS_PER_BIT`, 434: clock cycles per UART bit (50 MHz / 115200 baud); must be ≥ 4.
- `ADDR_W`, 8: instruction-memory word-address width.

Ports:
- `clk`  in  1  system clock (CLOCK_50).
- `rst`  in  1  reset, asynchronous, active-low.
- `rx`  in  1  UART serial input, idle high, asynchronous to `clk`.
- `we`  out  1  instruction-memory write strobe, one cycle per word.
- `wa`  out  ADDR_W  word address for the write.
- `wd`  out  32  instruction word for the write.
- `busy`  out  1  high while loading; OR'd into the CPU reset.
- `done`  out  1  one-cycle pulse after the final word of a frame is written.
- `err`  out  1  sticky error flag; cleared when the next valid header is accepted.
- `words`  out  ADDR_W+1  number of words written in the current or last frame.

## Operation
- Frame format: header byte 0xA5, count byte N, then N×4 data bytes. Each word is sent big-endian, MSB byte first. N = 0 means 2^ADDR_W words.
- UART receiver:
  - `rx` passes through a 2-flop synchronizer.
  - A falling edge starts a bit counter. The start bit is re-sampled at CLKS_PER_BIT/2; if it is high, treat it as a glitch and return to idle.
  - 8 data bits are sampled LSB first, one every CLKS_PER_BIT cycles from the start-bit midpoint.
  - The stop bit is sampled at its midpoint. High: one-cycle `byte_valid` with the byte. Low: one-cycle `frame_err`, no byte.
  - After the stop-bit sample, the receiver is ready for a new start edge immediately.
- Loader FSM states, with transitions:
  - S_HDR: wait for a byte equal to 0xA5 and ignore all other bytes. On 0xA5, clear `err` and `words` and go to S_CNT.
  - S_CNT: on the next byte, latch N and go to S_DATA with `wa` = 0 and byte index = 0.
  - S_DATA: shift each byte into a 32-bit assembly register. On the 4th byte, pulse `we` with `wd` = the assembled word, then increment `wa` and `words`. After word N, go to S_DONE.
  - S_DONE: pulse `done` for one cycle, then go to S_HDR.
- `busy` = 1 in S_CNT, S_DATA and S_DONE; otherwise 0.
- Errors:
  - `frame_err` in S_CNT or S_DATA: set `err`, abort to S_HDR, no further writes. Words already written stay in memory.
  - `frame_err` in S_HDR is ignored.
  - A 0xA5 byte arriving inside S_DATA is data, not a header.
- Reset values (asynchronous, `rst` low): `we`=0, `wa`=0, `wd`=0, `busy`=0, `done`=0, `err`=0, `words`=0, FSM=S_HDR, receiver idle. Reset mid-frame discards the partial word and never emits a spurious `we`.

## Timing
- Byte latency: `byte_valid` asserts 2 cycles (synchronizer) + 9.5 bit times after the `rx` falling edge, ±1 cycle.
- `we` asserts the cycle after the `byte_valid` of the 4th byte of a word. `wa` and `wd` are stable during that cycle; `wa` increments on the following edge.
- `done` asserts the cycle after the last `we`. `busy` falls together with `done`.
- `busy` rises the cycle after the header's `byte_valid`.
- Back-to-back frames are allowed: a header may arrive in the byte period immediately after the last data byte.

## Structure
- Package `loader_pkg`: HDR_BYTE = 8'hA5; FSM state typedef (S_HDR, S_CNT, S_DATA, S_DONE); receiver state typedef (R_IDLE, R_START, R_DATA, R_STOP).
- One sub-module, `uart_rx`: synchronizer plus bit-timing FSM, outputs `byte_valid`, `byte_data[7:0]`, `frame_err`. The loader FSM lives in `program_loader`.

## Test plan
All cases use CLKS_PER_BIT = 8 and ADDR_W = 8.
- Header 0xA5, N=2, bytes 20 08 00 05 / 20 09 00 03 -> `we` at wa=0 wd=0x20080005, `we` at wa=1 wd=0x20090003; `done` one cycle after, `words`=2, `busy` high from header+1 to `done`.
- Junk bytes 0x00, 0xFF, 0x5A before the header -> no `we`, `busy` stays 0; the following valid frame loads normally.
- Stop bit forced low on the 3rd data byte of N=1 -> `err`=1, `busy`=0, no `we`; the next valid frame clears `err`.
- 2-cycle low glitch on idle `rx` -> no byte, no state change.
- `rst` asserted after 6 of 8 data bytes (N=2) -> all outputs 0 immediately, one `we` total (word 0 only); after release, the FSM waits for a header.
- N=0 -> 256 writes with wa 0..255, `words`=256, single `done`.

Source files
------------

// File: rtl/program_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : loader_pkg
// Description : Shared constants and state encodings for the serial program
//               loader and its UART receiver.
// Revision    : 1.0 - initial release
// ============================================================================
package loader_pkg;

  // Start-of-frame marker byte.
  localparam logic [7:0] HDR_BYTE = 8'hA5;

  // Loader FSM states.
  typedef enum logic [1:0] {
    S_HDR  = 2'd0,
    S_CNT  = 2'd1,
    S_DATA = 2'd2,
    S_DONE = 2'd3
  } ld_state_e;

  // UART receiver bit-timing states.
  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_START = 2'd1,
    R_DATA  = 2'd2,
    R_STOP  = 2'd3
  } rx_state_e;

endpackage
`default_nettype wire

// File: rtl/program_loader_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : 8N1 UART receiver. Two-flop synchronizer on rx, falling-edge
//               start detection, start-bit glitch rejection at half a bit,
//               LSB-first data sampling at bit centres, stop-bit check.
// Ports       : clk        - system clock
//               rst_n      - asynchronous active-low reset
//               rx         - serial input, idle high, asynchronous
//               byte_valid - one-cycle strobe, byte_data holds the byte
//               byte_data  - received byte
//               frame_err  - one-cycle strobe when the stop bit is low
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
  import loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] c_bit_last  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] c_half_last = CNT_W'(CLKS_PER_BIT / 2 - 1);

  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             rx_meta_q, rx_meta_d;
  logic             rx_sync_q, rx_sync_d;
  logic             rx_prev_q, rx_prev_d;

  always_comb begin
    rx_meta_d = rx;
    rx_sync_d = rx_meta_q;
    rx_prev_d = rx_sync_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;

    case (state_q)
      R_IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          state_d = R_START;
          cnt_d   = '0;
        end
      end
      R_START: begin
        if (cnt_q == c_half_last) begin
          cnt_d = '0;
          // A line that is high again at mid-start was only a glitch.
          if (rx_sync_q) begin
            state_d = R_IDLE;
          end else begin
            state_d = R_DATA;
            bit_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      R_DATA: begin
        if (cnt_q == c_bit_last) begin
          cnt_d   = '0;
          shift_d = {rx_sync_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = R_STOP;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      R_STOP: begin
        if (cnt_q == c_bit_last) begin
          // Rearm right at the stop-bit centre so the next start edge,
          // which may come half a bit later, is not missed.
          cnt_d   = '0;
          state_d = R_IDLE;
          if (rx_sync_q) begin
            valid_d = 1'b1;
          end else begin
            ferr_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
      state_q   <= R_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      rx_meta_q <= rx_meta_d;
      rx_sync_q <= rx_sync_d;
      rx_prev_q <= rx_prev_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

  assign byte_valid = valid_q;
  assign byte_data  = shift_q;
  assign frame_err  = ferr_q;

endmodule
`default_nettype wire

// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
// Module      : program_loader
// Description : Serial boot loader. Receives "A5, N, N x 4 bytes" frames over
//               UART and writes big-endian 32-bit words into instruction
//               memory starting at word 0. busy holds the CPU in reset.
// Ports       : clk   - system clock
//               rst   - asynchronous active-low reset
//               rx    - UART serial input
//               we    - instruction-memory write strobe (one cycle per word)
//               wa    - write word address
//               wd    - write data
//               busy  - high while a frame is being loaded
//               done  - one-cycle pulse after the last word of a frame
//               err   - sticky framing error, cleared by the next header
//               words - words written in the current / last frame
// Revision    : 1.0 - initial release
// ============================================================================
module program_loader
  import loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int ADDR_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  output logic              we,
  output logic [ADDR_W-1:0] wa,
  output logic [31:0]       wd,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words
);

  // A count byte of zero means a full memory image.
  localparam logic [ADDR_W:0] c_full_count = (ADDR_W + 1)'(1) << ADDR_W;

  logic       byte_valid;
  logic [7:0] byte_data;
  logic       frame_err;

  uart_rx #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_uart_rx (
    .clk        (clk),
    .rst_n      (rst),
    .rx         (rx),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .frame_err  (frame_err)
  );

  ld_state_e         state_q, state_d;
  logic [ADDR_W:0]   n_q, n_d;
  logic [1:0]        idx_q, idx_d;
  logic [23:0]       asm_q, asm_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] wa_q, wa_d;
  logic [31:0]       wd_q, wd_d;
  logic              err_q, err_d;
  logic [ADDR_W:0]   words_q, words_d;
  logic [ADDR_W:0]   w_words_inc;
  logic [ADDR_W:0]   w_count;

  assign w_words_inc = words_q + (ADDR_W + 1)'(1);
  assign w_count     = (byte_data == 8'd0) ? c_full_count : (ADDR_W + 1)'(byte_data);

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    idx_d   = idx_q;
    asm_d   = asm_q;
    we_d    = 1'b0;
    wa_d    = wa_q;
    wd_d    = wd_q;
    err_d   = err_q;
    words_d = words_q;

    case (state_q)
      S_HDR: begin
        // Framing errors between frames are line noise and are ignored.
        if (byte_valid && (byte_data == HDR_BYTE)) begin
          state_d = S_CNT;
          err_d   = 1'b0;
          words_d = '0;
          wa_d    = '0;
        end
      end
      S_CNT: begin
        if (frame_err) begin
          err_d   = 1'b1;
          state_d = S_HDR;
        end else if (byte_valid) begin
          n_d     = w_count;
          idx_d   = '0;
          wa_d    = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        // Address and count advance on the edge that ends the write cycle,
        // so wa/wd are stable while we is high.
        if (we_q) begin
          wa_d    = wa_q + ADDR_W'(1);
          words_d = w_words_inc;
          if (w_words_inc == n_q) begin
            state_d = S_DONE;
          end
        end
        if (frame_err) begin
          err_d   = 1'b1;
          idx_d   = '0;
          state_d = S_HDR;
        end else if (byte_valid) begin
          idx_d = idx_q + 2'd1;
          asm_d = {asm_q[15:0], byte_data};
          if (idx_q == 2'd3) begin
            we_d = 1'b1;
            wd_d = {asm_q, byte_data};
          end
        end
      end
      S_DONE: begin
        state_d = S_HDR;
      end
      default: state_d = S_HDR;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_HDR;
      n_q     <= '0;
      idx_q   <= '0;
      asm_q   <= '0;
      we_q    <= 1'b0;
      wa_q    <= '0;
      wd_q    <= '0;
      err_q   <= 1'b0;
      words_q <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      asm_q   <= asm_d;
      we_q    <= we_d;
      wa_q    <= wa_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
      words_q <= words_d;
    end
  end

  assign we    = we_q;
  assign wa    = wa_q;
  assign wd    = wd_q;
  assign busy  = (state_q != S_HDR);
  assign done  = (state_q == S_DONE);
  assign err   = err_q;
  assign words = words_q;

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_program_loader
// Description : Self-checking bench for program_loader with a write
//               scoreboard (expected address/data queued as words are sent).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_program_loader;

  localparam int CPB = 8;
  localparam int AW  = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          rx  = 1'b1;
  logic          we;
  logic [AW-1:0] wa;
  logic [31:0]   wd;
  logic          busy;
  logic          done;
  logic          err;
  logic [AW:0]   words;

  int n_checks = 0;
  int n_fail   = 0;

  logic [AW+31:0] exp_q[$];
  int             we_cnt    = 0;
  int             done_cnt  = 0;
  bit             busy_seen = 1'b0;
  bit             we_prev   = 1'b0;
  bit             done_prev = 1'b0;
  logic [AW-1:0]  wa_last   = '0;

  program_loader #(
    .CLKS_PER_BIT (CPB),
    .ADDR_W       (AW)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .rx    (rx),
    .we    (we),
    .wa    (wa),
    .wd    (wd),
    .busy  (busy),
    .done  (done),
    .err   (err),
    .words (words)
  );

  always #5 clk = ~clk;

  // Write/done monitor: pops the scoreboard on every write strobe.
  always @(negedge clk) begin
    logic [AW+31:0] exp;
    logic [AW-1:0]  wa_exp;
    if (!rst) begin
      we_prev   = 1'b0;
      done_prev = 1'b0;
    end else begin
      if (we_prev) begin
        wa_exp = wa_last + 8'd1;
        n_checks++;
        if (wa !== wa_exp) begin
          n_fail++;
          $display("FAIL wa_increment: got %0d expected %0d", wa, wa_exp);
        end
      end
      if (done_prev) begin
        n_checks++;
        if (busy !== 1'b0) begin
          n_fail++;
          $display("FAIL busy_after_done: got %b expected 0", busy);
        end
      end
      if (we) begin
        we_cnt++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL write_unexpected: got wa=%0d wd=%h expected no write", wa, wd);
        end else begin
          exp = exp_q.pop_front();
          if ({wa, wd} !== exp) begin
            n_fail++;
            $display("FAIL write_data: got wa=%0d wd=%h expected wa=%0d wd=%h",
                     wa, wd, exp[AW+31:32], exp[31:0]);
          end
        end
      end
      if (done) begin
        done_cnt++;
        n_checks++;
        if (busy !== 1'b1) begin
          n_fail++;
          $display("FAIL busy_during_done: got %b expected 1", busy);
        end
      end
      if (busy) busy_seen = 1'b1;
      we_prev   = we;
      done_prev = done;
      wa_last   = wa;
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    rx = 1'b0;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(posedge clk);
    end
    rx = stop_ok;
    repeat (CPB) @(posedge clk);
    rx = 1'b1;
    if (!stop_ok) repeat (2 * CPB) @(posedge clk);
  endtask

  // Sends a word big-endian and queues the write it should produce.
  task automatic send_word(input logic [AW-1:0] addr, input logic [31:0] w);
    exp_q.push_back({addr, w});
    send_byte(w[31:24], 1'b1);
    send_byte(w[23:16], 1'b1);
    send_byte(w[15:8],  1'b1);
    send_byte(w[7:0],   1'b1);
  endtask

  task automatic settle();
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({we, wa, wd, busy, done, err, words} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got we=%b wa=%0d wd=%h busy=%b done=%b err=%b words=%0d expected all 0",
               we, wa, wd, busy, done, err, words);
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_basic();
    int we0, done0;
    we0 = we_cnt; done0 = done_cnt;
    send_byte(8'hA5, 1'b1);
    #1;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_busy_rise: got %b expected 1", busy);
    end
    send_byte(8'h02, 1'b1);
    send_word(8'd0, 32'h2008_0005);
    send_word(8'd1, 32'h2009_0003);
    settle();
    n_checks++;
    if (we_cnt - we0 !== 2) begin
      n_fail++;
      $display("FAIL basic_we_count: got %0d expected 2", we_cnt - we0);
    end
    n_checks++;
    if (done_cnt - done0 !== 1) begin
      n_fail++;
      $display("FAIL basic_done_count: got %0d expected 1", done_cnt - done0);
    end
    n_checks++;
    if (words !== 9'd2 || busy !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_final: got words=%0d busy=%b err=%b expected 2 0 0", words, busy, err);
    end
  endtask

  task automatic test_junk();
    int we0;
    we0 = we_cnt;
    busy_seen = 1'b0;
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h5A, 1'b1);
    settle();
    n_checks++;
    if (busy_seen !== 1'b0 || we_cnt !== we0) begin
      n_fail++;
      $display("FAIL junk_ignored: got busy_seen=%b writes=%0d expected 0 0", busy_seen, we_cnt - we0);
    end
    // Header bytes inside the data phase are ordinary data.
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_word(8'd0, 32'hA500_A511);
    settle();
    n_checks++;
    if (words !== 9'd1 || we_cnt - we0 !== 1) begin
      n_fail++;
      $display("FAIL junk_then_frame: got words=%0d writes=%0d expected 1 1", words, we_cnt - we0);
    end
  endtask

  task automatic test_frame_err();
    int we0;
    we0 = we_cnt;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b0);
    settle();
    n_checks++;
    if (err !== 1'b1 || busy !== 1'b0 || we_cnt !== we0) begin
      n_fail++;
      $display("FAIL frame_err_abort: got err=%b busy=%b writes=%0d expected 1 0 0",
               err, busy, we_cnt - we0);
    end
    send_byte(8'hA5, 1'b1);
    #1;
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL frame_err_clear: got err=%b expected 0", err);
    end
    send_byte(8'h01, 1'b1);
    send_word(8'd0, 32'h1234_5678);
    settle();
    n_checks++;
    if (we_cnt - we0 !== 1 || words !== 9'd1) begin
      n_fail++;
      $display("FAIL frame_err_reload: got writes=%0d words=%0d expected 1 1", we_cnt - we0, words);
    end
  endtask

  task automatic test_glitch();
    int we0;
    logic [AW:0] words0;
    we0 = we_cnt; words0 = words;
    busy_seen = 1'b0;
    @(posedge clk);
    rx = 1'b0;
    repeat (2) @(posedge clk);
    rx = 1'b1;
    repeat (12 * CPB) @(posedge clk);
    #1;
    n_checks++;
    if (busy_seen !== 1'b0 || err !== 1'b0 || words !== words0 || we_cnt !== we0) begin
      n_fail++;
      $display("FAIL glitch_ignored: got busy_seen=%b err=%b words=%0d writes=%0d expected 0 0 %0d 0",
               busy_seen, err, words, we_cnt - we0, words0);
    end
  endtask

  task automatic test_reset_mid();
    int we0;
    we0 = we_cnt;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    send_word(8'd0, 32'hDEAD_BEEF);
    send_byte(8'hCA, 1'b1);
    send_byte(8'hFE, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if ({we, wa, wd, busy, done, err, words} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got we=%b wa=%0d wd=%h busy=%b done=%b err=%b words=%0d expected all 0",
               we, wa, wd, busy, done, err, words);
    end
    repeat (3) @(posedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    // The remaining word's bytes now arrive without a header.
    send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1);
    settle();
    n_checks++;
    if (we_cnt - we0 !== 1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_no_write: got writes=%0d busy=%b expected 1 0", we_cnt - we0, busy);
    end
  endtask

  task automatic test_back_to_back();
    int done0;
    done0 = done_cnt;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_word(8'd0, 32'h0BAD_F00D);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_word(8'd0, 32'hC0FF_EE00);
    settle();
    n_checks++;
    if (done_cnt - done0 !== 2 || exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL back_to_back: got done=%0d pending=%0d expected 2 0", done_cnt - done0, exp_q.size());
    end
  endtask

  task automatic test_full_image();
    int we0, done0;
    logic [7:0] b;
    we0 = we_cnt; done0 = done_cnt;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    for (int i = 0; i < 256; i++) begin
      b = 8'(i);
      send_word(b, {b, ~b, b ^ 8'h5A, 8'h3C});
    end
    settle();
    n_checks++;
    if (we_cnt - we0 !== 256 || words !== 9'd256) begin
      n_fail++;
      $display("FAIL full_image_count: got writes=%0d words=%0d expected 256 256", we_cnt - we0, words);
    end
    n_checks++;
    if (done_cnt - done0 !== 1 || busy !== 1'b0 || wa !== 8'd0) begin
      n_fail++;
      $display("FAIL full_image_end: got done=%0d busy=%b wa=%0d expected 1 0 0", done_cnt - done0, busy, wa);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_junk();
    test_frame_err();
    test_glitch();
    test_reset_mid();
    test_back_to_back();
    test_full_image();
    n_checks++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending writes expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
